// File: rtl/serial_bit_compare.sv
// Bit-serial MSB-first magnitude comparator with unsigned / two's-complement
// modes, a start/busy/done handshake and optional early exit.
module serial_bit_compare #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       eq,
    output logic                       neq,
    output logic                       gt,
    output logic                       lt,
    output logic [$clog2(WIDTH+1)-1:0] cycles
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] bias_msb(input logic [WIDTH-1:0] v,
                                                  input logic en);
        return {v[WIDTH-1] ^ en, v[WIDTH-2:0]};
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sa_r, sa_s, sb_r, sb_s;
    logic [CW-1:0]    count_r, count_s;
    logic             seen_r, seen_s;
    logic             dir_gt_r, dir_gt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             eq_r, eq_s, neq_r, neq_s, gt_r, gt_s, lt_r, lt_s;
    logic [CW-1:0]    cycles_r, cycles_s;

    logic bit_a_s, bit_b_s, differ_s, last_s, any_diff_s, res_gt_s;

    assign bit_a_s    = sa_r[WIDTH-1];
    assign bit_b_s    = sb_r[WIDTH-1];
    assign differ_s   = bit_a_s ^ bit_b_s;
    assign last_s     = (EARLY_EXIT && differ_s) || (count_r == LAST_CNT);
    assign any_diff_s = seen_r | differ_s;
    assign res_gt_s   = seen_r ? dir_gt_r : (differ_s & bit_a_s);

    // Next-state, datapath and result computation.
    always_comb begin
        state_s  = state_r;
        sa_s     = sa_r;
        sb_s     = sb_r;
        count_s  = count_r;
        seen_s   = seen_r;
        dir_gt_s = dir_gt_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        eq_s     = eq_r;
        neq_s    = neq_r;
        gt_s     = gt_r;
        lt_s     = lt_r;
        cycles_s = cycles_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sa_s     = bias_msb(a, signed_mode);
                    sb_s     = bias_msb(b, signed_mode);
                    count_s  = {CW{1'b0}};
                    seen_s   = 1'b0;
                    dir_gt_s = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                sa_s    = {sa_r[WIDTH-2:0], 1'b0};
                sb_s    = {sb_r[WIDTH-2:0], 1'b0};
                count_s = count_r + CW'(1);
                // The direction latch only records the first differing bit.
                if (differ_s && !seen_r) begin
                    seen_s   = 1'b1;
                    dir_gt_s = bit_a_s;
                end else begin
                    seen_s = seen_r;
                end
                if (last_s) begin
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = IDLE;
                    eq_s     = ~any_diff_s;
                    neq_s    = any_diff_s;
                    gt_s     = res_gt_s;
                    lt_s     = any_diff_s & ~res_gt_s;
                    cycles_s = count_r + CW'(1);
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            seen_r   <= 1'b0;
            dir_gt_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            eq_r     <= 1'b0;
            neq_r    <= 1'b0;
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            cycles_r <= {CW{1'b0}};
        end else begin
            state_r  <= state_s;
            sa_r     <= sa_s;
            sb_r     <= sb_s;
            count_r  <= count_s;
            seen_r   <= seen_s;
            dir_gt_r <= dir_gt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            eq_r     <= eq_s;
            neq_r    <= neq_s;
            gt_r     <= gt_s;
            lt_r     <= lt_s;
            cycles_r <= cycles_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign eq     = eq_r;
    assign neq    = neq_r;
    assign gt     = gt_r;
    assign lt     = lt_r;
    assign cycles = cycles_r;

endmodule
